// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch unit and its return-address stack.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_SEQ,
    NPC_BR,
    NPC_JMP,
    NPC_RET
  } npc_sel_t;

  localparam int INSTR_BYTES = 4;
  localparam int JIDX_W      = 26;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push/pop, saturating count, sticky overflow/underflow.
module return_addr_stack
  import mips_fetch_pkg::*;
#(
  parameter int   ADDR_W    = 32,
  parameter int   RAS_DEPTH = 4,
  localparam int  PTR_W     = $clog2(RAS_DEPTH),
  localparam int  CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  tos;
  logic [PTR_W-1:0]  tos_inc;
  logic [PTR_W-1:0]  wr_ptr;
  logic              full;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign do_pop  = pop & ~empty;
  assign tos_inc = tos + PTR_W'(1);
  // Pop-then-push rewrites the current top in place instead of advancing.
  assign wr_ptr  = do_pop ? tos : tos_inc;
  assign top     = mem[tos];

  // NOTE: stack storage has no reset; entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tos       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !do_pop) begin
        tos <= tos_inc;
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else if (do_pop && !push) begin
        tos   <= tos - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Program counter and next-PC selection for the MIPS single-cycle core.
// Define MIPS_FETCH_RAS_EN to build the return-address stack; otherwise jr always uses jr_target.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                RAS_DEPTH = 4,
  localparam int               CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic              link,
  input  logic              ret,
  input  logic [JIDX_W-1:0] jump_idx,
  input  logic [ADDR_W-1:0] se_imm,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  npc_sel_t          npc_sel;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] ret_target;

  assign pc_plus4  = pc + ADDR_W'(INSTR_BYTES);
  assign br_target = pc_plus4 + (se_imm << 2);

  // With a 28-bit PC the jump index plus word offset fills the whole address.
  generate
    if (ADDR_W > JIDX_W + 2) begin : g_jmp_region
      assign jmp_target = {pc_plus4[ADDR_W-1:JIDX_W+2], jump_idx, 2'b00};
    end else begin : g_jmp_full
      assign jmp_target = {jump_idx, 2'b00};
    end
  endgenerate

`ifdef MIPS_FETCH_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  return_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (link & ~stall),
    .pop       (ret & ~stall),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign ret_target = ras_empty ? jr_target : ras_top;
`else
  logic unused_link;

  assign unused_link   = link;
  assign ret_target    = jr_target;
  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // NOTE: defaulting npc_sel before the priority chain keeps this block free of latches.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (stall) begin
      npc_sel = NPC_HOLD;
    end else if (jump) begin
      npc_sel = NPC_JMP;
    end else if (ret) begin
      npc_sel = NPC_RET;
    end else if (branch && zero) begin
      npc_sel = NPC_BR;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    unique case (npc_sel)
      NPC_HOLD: next_pc = pc;
      NPC_SEQ:  next_pc = pc_plus4;
      NPC_BR:   next_pc = br_target;
      NPC_JMP:  next_pc = jmp_target;
      NPC_RET:  next_pc = ret_target;
      default:  next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a queue-based reference model checked every cycle.
module tb_mips_fetch_unit;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RV     = 32'h0040_0000;
`ifdef MIPS_FETCH_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, branch, zero, jump, link, ret;
  logic [25:0] jump_idx;
  logic [31:0] se_imm, jr_target;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          armed = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_udf;

  mips_fetch_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .link          (link),
    .ret           (ret),
    .jump_idx      (jump_idx),
    .se_imm        (se_imm),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: next PC from priority rules, RAS as a bounded LIFO queue.
  task automatic model_step();
    logic [31:0] p4, nxt;
    if (rst) begin
      m_pc = RV;
      m_ras.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      armed = 1'b1;
      return;
    end
    if (!armed || stall) return;
    p4  = m_pc + 32'd4;
    nxt = p4;
    if (branch && zero) nxt = p4 + (se_imm * 4);
    if (ret) nxt = (RAS_EN && m_ras.size() > 0) ? m_ras[$] : jr_target;
    if (jump) nxt = {p4[31:28], jump_idx, 2'b00};
    if (RAS_EN) begin
      if (ret) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_udf = 1'b1;
      end
      if (link) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
    end
    m_pc = nxt;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (armed) begin
      check("model_pc", pc, m_pc);
      check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("model_ras_count", 32'(ras_count), 32'(m_ras.size()));
      check("model_overflow", 32'(ras_overflow), 32'(m_ovf));
      check("model_underflow", 32'(ras_underflow), 32'(m_udf));
    end
  end

  task automatic clear();
    rst = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    jump = 1'b0; link = 1'b0; ret = 1'b0;
    jump_idx = '0; se_imm = '0; jr_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic do_jump(input logic [31:0] target, input bit lnk);
    jump = 1'b1;
    link = lnk;
    jump_idx = target[27:2];
  endtask

  logic [31:0] exp_ret [4] = '{32'h54, 32'h44, 32'h34, 32'h24};

  initial begin
    clear();
    rst = 1'b1;
    tick();
    check("reset_pc", pc, RV);
    check("reset_count", 32'(ras_count), 32'd0);
    check("reset_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    check("seq_pc_1", pc, 32'h0040_0004);
    tick();
    check("seq_pc_2", pc, 32'h0040_0008);

    do_jump(32'h100, 1'b0); tick();
    check("jump_to_100", pc, 32'h100);
    branch = 1'b1; zero = 1'b1; se_imm = 32'hFFFF_FFFC; tick();
    check("branch_neg_taken", pc, 32'h0F4);
    do_jump(32'h100, 1'b0); tick();
    branch = 1'b1; zero = 1'b0; se_imm = 32'hFFFF_FFFC; tick();
    check("branch_not_taken", pc, 32'h104);

    ret = 1'b1; jr_target = 32'hFFFF_FFFC; tick();
    check("jr_empty_target", pc, 32'hFFFF_FFFC);
    check("jr_empty_underflow", 32'(ras_underflow), 32'(RAS_EN));
    tick();
    check("pc_wrap", pc, 32'h0);
    ret = 1'b1; jr_target = 32'h1000_0000; tick();
    jump = 1'b1; jump_idx = 26'h40; tick();
    check("jump_region", pc, 32'h1000_0100);

    rst = 1'b1; tick();
    check("rst_clears_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    do_jump(32'h10, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      do_jump(32'h20 + 32'h10 * i, 1'b1); tick();
      check("jal_pc", pc, 32'h20 + 32'h10 * i);
    end
    check("ras_full_count", 32'(ras_count), RAS_EN ? 32'd4 : 32'd0);
    check("ras_overflow", 32'(ras_overflow), 32'(RAS_EN));
    for (int k = 0; k < 4; k++) begin
      ret = 1'b1; jr_target = 32'h900; tick();
      check("ret_target", pc, RAS_EN ? exp_ret[k] : 32'h900);
    end
    ret = 1'b1; jr_target = 32'h800; tick();
    check("ret_underflow_pc", pc, 32'h800);
    check("ret_underflow_flag", 32'(ras_underflow), 32'(RAS_EN));
    check("ret_underflow_count", 32'(ras_count), 32'd0);

    rst = 1'b1; tick();
    for (int s = 0; s < 3; s++) begin
      stall = 1'b1; do_jump(32'h200, 1'b1); tick();
      check("stall_pc", pc, RV);
      check("stall_count", 32'(ras_count), 32'd0);
    end
    do_jump(32'h200, 1'b1); tick();
    check("stall_release_pc", pc, 32'h200);
    check("stall_release_count", 32'(ras_count), 32'(RAS_EN));
    tick();
    check("stall_once_pc", pc, 32'h204);
    check("stall_once_count", 32'(ras_count), 32'(RAS_EN));

    do_jump(32'h1FC, 1'b0); tick();
    do_jump(32'h300, 1'b1); tick();
    check("jal_300", pc, 32'h300);
    ret = 1'b1; link = 1'b1; jr_target = 32'h900; tick();
    check("ret_link_pc", pc, RAS_EN ? 32'h200 : 32'h900);
    check("ret_link_count", 32'(ras_count), RAS_EN ? 32'd2 : 32'd0);
    check("ret_link_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    ret = 1'b1; jr_target = 32'h900; tick();
    check("ret_after_link", pc, RAS_EN ? 32'h304 : 32'h900);

    rst = 1'b1; ret = 1'b1; link = 1'b1; jr_target = 32'h900; tick();
    check("mid_rst_pc", pc, RV);
    check("mid_rst_count", 32'(ras_count), 32'd0);
    ret = 1'b1; jr_target = 32'hA00; tick();
    check("post_rst_ret", pc, 32'hA00);
    check("post_rst_underflow", 32'(ras_underflow), 32'(RAS_EN));

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised program-counter and next-PC unit for the MIPS single-cycle core. It replaces the fixed 32-bit PC register, PC+4 adder, branch adder and branch/jump multiplexers with one block. It adds configurable address width, a reset vector, fetch stall, register-indirect return (`jr`), and an optional return-address stack (RAS). It sits between the control/decode logic (branch, jump, immediate and register inputs) and instruction memory (`pc` output).

## Interface
- `ADDR_W`, 32: PC width in bits; legal range 28..32.
- `RESET_VEC`, 0: PC value loaded on reset; word aligned.
- `RAS_DEPTH`, 4: RAS entries; power of two, at least 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hold PC and RAS this cycle.
- `branch`  in  1  conditional-branch instruction.
- `zero`  in  1  ALU zero flag; branch is taken when `branch & zero`.
- `jump`  in  1  J-type jump.
- `link`  in  1  jump-and-link; push return address.
- `ret`  in  1  return (`jr`).
- `jump_idx`  in  26  J-type instruction index.
- `se_imm`  in  ADDR_W  sign-extended branch immediate, in words.
- `jr_target`  in  ADDR_W  register-file value for `jr`.
- `pc`  out  ADDR_W  current fetch address.
- `pc_plus4`  out  ADDR_W  `pc + 4`, combinational.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- `ras_overflow`  out  1  sticky; set when a push overwrites a live entry.
- `ras_underflow`  out  1  sticky; set when a pop occurs on an empty stack.

## Operation
- Next-PC priority, highest first: `stall` (hold), then `jump`, then `ret`, then taken branch, then sequential.
- Sequential: `pc_plus4`.
- Taken branch: `pc_plus4 + (se_imm << 2)`, truncated to ADDR_W (modulo 2^ADDR_W wrap).
- Jump: {`pc_plus4[ADDR_W-1:28]`, `jump_idx`, 2'b00}. When ADDR_W = 28 the upper field is empty.
- Return with RAS non-empty: target is the RAS top entry. Return with RAS empty: target is `jr_target` and `ras_underflow` is set.
- `link` pushes `pc_plus4`. There is no delay slot.
- `link` is honoured alongside `jump` or `ret`; when asserted alone it pushes and the PC advances sequentially.
- RAS is circular with pointer `tos`:
  - Push: write at `tos+1`, advance `tos`, increment count.
  - Pop: read at `tos`, decrement `tos` and count.
- Push when full (count = RAS_DEPTH): overwrite the oldest entry by wrap, count saturates, `ras_overflow` is set.
- Simultaneous `ret` and `link`: pop then push. The top is replaced by `pc_plus4`, count is unchanged, and no flag is raised.
- `ret` together with `jump`: jump wins. The pop is still performed.
- `stall`: PC, RAS contents, pointer, count and flags all hold. Push and pop are suppressed.
- Reset values: `pc` = RESET_VEC, `ras_count` = 0, `tos` = 0, both flags = 0. RAS data is not cleared. Reset mid-operation discards all stacked return addresses.

## Timing
- Next-PC is combinational from the inputs in the same cycle.
- `pc`, the RAS, `ras_count` and the flags update on the rising edge of `clk`. Latency from input to `pc` is 1 cycle.
- `pc_plus4` follows `pc` combinationally with zero added latency.
- `rst` overrides `stall` and all other inputs on the edge where it is sampled high.
- A return's target reflects a push made in an earlier cycle, never one made in the same cycle.

## Configuration
- `MIPS_FETCH_RAS_EN` defined: RAS is built as described above.
- Not defined:
  - No RAS storage.
  - `ret` always targets `jr_target`.
  - `link` has no effect on state.
  - `ras_count`, `ras_overflow` and `ras_underflow` are tied to 0.

## Structure
- Shared package `mips_fetch_pkg` holds:
  - `npc_sel_t` enum: NPC_HOLD, NPC_SEQ, NPC_BR, NPC_JMP, NPC_RET.
  - Constant `INSTR_BYTES` = 4.
  - Constant `JIDX_W` = 26.
- Sub-module `return_addr_stack`, parameters ADDR_W and RAS_DEPTH, contains the push/pop/count/flag logic. The top-level instantiates it only under `MIPS_FETCH_RAS_EN`.

## Test plan
- Reset and sequential fetch: RESET_VEC = 0x0040_0000, `rst` high 2 cycles then low, no controls asserted -> `pc` reads 0x0040_0000, 0x0040_0004, 0x0040_0008; flags 0.
- Negative taken branch: `pc` = 0x100, `branch` = `zero` = 1, `se_imm` = 0xFFFF_FFFC -> next `pc` = 0x0F4. Same stimulus with `zero` = 0 -> next `pc` = 0x104.
- Jump and wrap: `pc` = 0xFFFF_FFFC, sequential -> `pc` = 0. Then `pc` = 0x1000_0000, `jump`, `jump_idx` = 0x0000_040 -> `pc` = 0x1000_0100.
- RAS round trip with RAS_DEPTH = 4:
  - Five `jump`+`link` cycles from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> `ras_count` = 4, `ras_overflow` = 1.
  - Four `ret` cycles -> targets 0x54, 0x44, 0x34, 0x24.
  - A fifth `ret` with `jr_target` = 0x800 -> `pc` = 0x800, `ras_underflow` = 1.
- Stall: assert `stall` for 3 cycles during `jump`+`link` -> `pc`, `ras_count` and flags unchanged. On release the jump and push take effect once.
- Same-cycle link and return: `ret`+`link` with RAS top = 0x200 and `pc` = 0x300 -> `pc` = 0x200, `ras_count` unchanged, top = 0x304. A mid-sequence `rst` -> `ras_count` = 0, `pc` = RESET_VEC.
